b10_counter: RTL and testbench

- Synchronous N-digit BCD up-counter. The state register feeds a chain of N base-10 half adders: one b10_halfadder per digit, carry rippling from digit 0 upward.
- Each adder's sum output is written back into the register, so the adder chain is both fed and consumed by this block.
- Provides parallel BCD load, terminal-count and wrap indications, and a sticky error flag for illegal load data.
- Used as the decimal event/time counter ahead of display and compare logic.

---
 rtl/b10_counter_if.sv | 41 ++++
 rtl/b10_counter.sv | 95 +++++++++
 tb/tb_b10_counter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/b10_counter_if.sv
// Bundles the control, load and status signals of the BCD counter.
//   en    - count enable (master -> slave)
//   load  - parallel load request (master -> slave)
//   d     - BCD load value, digit i at d[4i+3:4i] (master -> slave)
//   q     - current BCD count (slave -> master)
//   tc    - terminal count, all digits 9 (slave -> master)
//   cout  - registered wrap pulse (slave -> master)
//   err   - sticky illegal-load flag (slave -> master)
interface b10_counter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned W = 4 * N;

    logic         en;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc;
    logic         cout;
    logic         err;

    modport master (
        output en,
        output load,
        output d,
        input  q,
        input  tc,
        input  cout,
        input  err
    );

    modport slave (
        input  en,
        input  load,
        input  d,
        output q,
        output tc,
        output cout,
        output err
    );
endinterface

// File: rtl/b10_counter.sv
// N-digit synchronous BCD up-counter with parallel load.
//   clock - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - b10_counter_if slave: en, load, d in; q, tc, cout, err out
// The register feeds a ripple chain of base-10 half adders whose sums are
// written back as the next count; the top carry becomes the cout pulse.

// Single BCD digit plus a one-bit carry-in.
//   a_i    - digit 0..9
//   cin_i  - carry in
//   sum_o  - (a_i + cin_i) mod 10
//   cout_o - 1 when the digit wraps 9 -> 0
module b10_halfadder (
    input  logic [3:0] a_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic wrap_c;

    always_comb begin
        wrap_c = (a_i == 4'd9) && cin_i;
        cout_o = wrap_c;
        sum_o  = wrap_c ? 4'd0 : 4'(a_i + 4'(cin_i));
    end
endmodule

module b10_counter #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset,
    b10_counter_if.slave bus
);
    localparam int unsigned W = 4 * N;

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         cout_q;
    logic         err_q;
    logic [N:0]   carry;
    logic         load_legal_c;
    logic         tc_c;

    // Increment chain: en is the carry into digit 0, so en=0 yields q unchanged.
    assign carry[0] = bus.en;

    for (genvar i = 0; i < int'(N); i++) begin : g_digit
        b10_halfadder u_ha (
            .a_i    (q_q[4*i +: 4]),
            .cin_i  (carry[i]),
            .sum_o  (q_d[4*i +: 4]),
            .cout_o (carry[i+1])
        );
    end

    // Load legality check on d and terminal-count decode on q.
    always_comb begin
        load_legal_c = 1'b1;
        tc_c         = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            if (bus.d[4*i +: 4] > 4'd9) begin
                load_legal_c = 1'b0;
            end
            if (q_q[4*i +: 4] != 4'd9) begin
                tc_c = 1'b0;
            end
        end
    end

    // State update, priority reset > load > count/hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q    <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (bus.load) begin
            cout_q <= 1'b0;
            if (load_legal_c) begin
                q_q   <= bus.d;
                err_q <= 1'b0;
            end else begin
                err_q <= 1'b1;
            end
        end else begin
            q_q    <= q_d;
            cout_q <= carry[N];
        end
    end

    assign bus.q    = q_q;
    assign bus.tc   = tc_c;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_b10_counter.sv
// Self-checking bench for b10_counter (N = 4): directed vector table,
// hand-written multi-cycle sequences and random traffic against an
// integer-arithmetic reference model.
module tb_b10_counter;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 4 * N;
    localparam int          MOD = 10000;

    logic clock;
    logic reset;

    b10_counter_if #(.N(N)) bus ();

    b10_counter #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state: count as a plain integer.
    int m_val;
    bit m_cout;
    bit m_err;

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(N); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [W-1:0] v);
        for (int i = 0; i < int'(N); i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = int'(N) - 1; i >= 0; i--)
            r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input bit r, input bit l, input bit e, input logic [W-1:0] dd);
        @(negedge clock);
        reset    = r;
        bus.load = l;
        bus.en   = e;
        bus.d    = dd;
        @(posedge clock);
        if (r) begin
            m_val = 0; m_cout = 0; m_err = 0;
        end else if (l) begin
            m_cout = 0;
            if (bcd_ok(dd)) begin
                m_val = bcd2int(dd); m_err = 0;
            end else begin
                m_err = 1;
            end
        end else if (e) begin
            m_cout = (m_val == MOD - 1);
            m_val  = (m_val + 1) % MOD;
        end else begin
            m_cout = 0;
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".q"},    32'(bus.q),    32'(int2bcd(m_val)));
        chk({tag, ".tc"},   32'(bus.tc),   32'(m_val == MOD - 1));
        chk({tag, ".cout"}, 32'(bus.cout), 32'(m_cout));
        chk({tag, ".err"},  32'(bus.err),  32'(m_err));
    endtask

    typedef struct {
        bit           r;
        bit           l;
        bit           e;
        logic [W-1:0] d;
        logic [W-1:0] q;
        bit           tc;
        bit           cout;
        bit           err;
    } vec_t;

    vec_t vt[$];

    initial begin
        reset    = 1'b0;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.d    = '0;
        m_val = 0; m_cout = 0; m_err = 0;

        //        r  l  e  d         q         tc cout err
        vt.push_back('{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0});
        vt.push_back('{0, 1, 0, 16'h0999, 16'h0999, 0, 0, 0});
        vt.push_back('{0, 0, 1, 16'h0000, 16'h1000, 0, 0, 0});
        vt.push_back('{0, 1, 0, 16'h9998, 16'h9998, 0, 0, 0});
        vt.push_back('{0, 0, 1, 16'h0000, 16'h9999, 1, 0, 0});
        vt.push_back('{0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0});
        vt.push_back('{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0});
        vt.push_back('{0, 1, 1, 16'h1234, 16'h1234, 0, 0, 0});
        vt.push_back('{0, 1, 0, 16'h12A4, 16'h1234, 0, 0, 1});
        vt.push_back('{0, 0, 1, 16'h0000, 16'h1235, 0, 0, 1});
        vt.push_back('{0, 1, 0, 16'h0042, 16'h0042, 0, 0, 0});
        vt.push_back('{0, 1, 0, 16'h5678, 16'h5678, 0, 0, 0});
        vt.push_back('{0, 1, 1, 16'h56F8, 16'h5678, 0, 0, 1});
        vt.push_back('{1, 1, 1, 16'h1111, 16'h0000, 0, 0, 0});
        vt.push_back('{0, 0, 1, 16'h0000, 16'h0001, 0, 0, 0});
        vt.push_back('{0, 1, 0, 16'h9999, 16'h9999, 1, 0, 0});
        vt.push_back('{0, 1, 1, 16'hFFFF, 16'h9999, 1, 0, 1});
        vt.push_back('{0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1});
        vt.push_back('{0, 0, 1, 16'h0000, 16'h0001, 0, 0, 1});

        foreach (vt[i]) begin
            step(vt[i].r, vt[i].l, vt[i].e, vt[i].d);
            chk($sformatf("vec%0d.q", i),    32'(bus.q),    32'(vt[i].q));
            chk($sformatf("vec%0d.tc", i),   32'(bus.tc),   32'(vt[i].tc));
            chk($sformatf("vec%0d.cout", i), 32'(bus.cout), 32'(vt[i].cout));
            chk($sformatf("vec%0d.err", i),  32'(bus.err),  32'(vt[i].err));
        end

        // Count from reset: 12 increments read 0001..0012.
        step(1, 0, 0, '0);
        chk("cnt.rst.q", 32'(bus.q), 32'h0);
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 1, '0);
            chk($sformatf("cnt%0d.q", i), 32'(bus.q), 32'(int2bcd(i)));
            chk_model($sformatf("cnt%0d", i));
        end

        // Hold at 0420 with err set; tc must ignore en while sitting at 9999.
        step(0, 1, 0, 16'h0420);
        step(0, 1, 0, 16'hB420);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, '0);
            chk($sformatf("hold%0d.q", i),   32'(bus.q),   32'h0420);
            chk($sformatf("hold%0d.err", i), 32'(bus.err), 32'h1);
            chk_model($sformatf("hold%0d", i));
        end
        step(0, 1, 0, 16'h9999);
        @(negedge clock);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        #1 chk("tc.en1", 32'(bus.tc), 32'h1);
        bus.en   = 1'b0;
        #1 chk("tc.en0", 32'(bus.tc), 32'h1);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            bit r, l, e;
            logic [W-1:0] dd;
            r = ($urandom_range(0, 49) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       dd = W'($urandom);
                1:       dd = int2bcd(int'($urandom_range(MOD - 12, MOD - 1)));
                default: dd = int2bcd(int'($urandom_range(0, MOD - 1)));
            endcase
            step(r, l, e, dd);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
